irq_pending_ctrl: RTL and testbench

Request-capture and hand-off stage sitting directly upstream of the 8-input priority encoder. It samples eight raw request lines and holds them as sticky pending bits under a per-line enable mask. It presents the pending vector to the encoder. It then issues the highest-priority eligible request to a consumer over a valid/ack handshake and tracks one in-service request until end-of-interrupt. Line 7 has the highest priority and line 0 the lowest, matching the encoder's ordering.

---
 rtl/irq_pending_ctrl_pkg.sv | 23 ++
 rtl/irq_pending_ctrl_if.sv | 28 ++
 rtl/irq_pending_ctrl_prio_sel.sv | 18 +
 rtl/irq_pending_ctrl.sv | 82 ++++++++
 tb/tb_irq_pending_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and constants for the interrupt pending/hand-off stage.
// Line 7 has the highest priority, matching the downstream priority encoder.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [N_REQ-1:0] EN_RESET_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request, mask and consumer handshake bundle for irq_pending_ctrl.
// The slave modport is the controller; master is the requester/consumer side.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic [N_REQ-1:0] req_i;
  logic             en_we;
  logic [N_REQ-1:0] en_wdata;
  logic             irq_ack;
  logic             irq_eoi;
  logic [N_REQ-1:0] pend_o;
  logic [N_REQ-1:0] en_o;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic             busy;
  logic             none_pend;

  modport slave (
    input  req_i, en_we, en_wdata, irq_ack, irq_eoi,
    output pend_o, en_o, irq_valid, irq_id, busy, none_pend
  );

  modport master (
    output req_i, en_we, en_wdata, irq_ack, irq_eoi,
    input  pend_o, en_o, irq_valid, irq_id, busy, none_pend
  );

endinterface

// File: rtl/irq_pending_ctrl_prio_sel.sv
// Combinational highest-set-bit selector; bit N-1 wins, same order as the encoder.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (d[i]) idx = i[ID_W-1:0];
  end

  assign any = |d;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture under an enable mask, then one-at-a-time hand-off
// of the highest-priority eligible line over valid/ack, held until eoi.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter bit               EDGE_MODE = 1'b1,
  parameter logic [N_REQ-1:0] EN_RESET  = EN_RESET_DEF
) (
  input  logic             clk,
  input  logic             rst,
  irq_pending_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_REQ-1:0] req_q, pend_q, en_q;
  logic [N_REQ-1:0] rise, clr, elig;
  logic [ID_W-1:0]  win;
  logic             any;

  assign rise = EDGE_MODE ? (bus.req_i & ~req_q) : bus.req_i;
  assign elig = pend_q & en_q;

  irq_prio_sel u_sel (
    .d   (elig),
    .idx (win),
    .any (any)
  );

  // Per-line sticky bit; a rise in the ack cycle beats the clear so no event is lost.
  for (genvar n = 0; n < N_REQ; n++) begin : g_line
    always_ff @(posedge clk) begin
      if (rst) pend_q[n] <= 1'b0;
      else     pend_q[n] <= (pend_q[n] & ~clr[n]) | rise[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      req_q   <= '0;
      en_q    <= EN_RESET;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= bus.req_i;
      if (bus.en_we) en_q <= bus.en_wdata;
    end
  end

  // No preemption or withdrawal: once offered, id is frozen until eoi.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE:
        if (any) begin
          id_d    = win;
          state_d = OFFER;
        end
      OFFER:
        if (bus.irq_ack) begin
          clr     = id_onehot(id_q);
          state_d = SERVICE;
        end
      SERVICE:
        if (bus.irq_eoi) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  assign bus.pend_o    = pend_q;
  assign bus.en_o      = en_q;
  assign bus.irq_valid = (state_q == OFFER);
  assign bus.busy      = (state_q == SERVICE);
  assign bus.irq_id    = id_q;
  assign bus.none_pend = ~|elig;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed table-driven bench for irq_pending_ctrl plus a hand-written reset-in-service sequence.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl #(.EDGE_MODE(1'b1), .EN_RESET(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] req;
    logic       we;
    logic [7:0] wd;
    logic       ack;
    logic       eoi;
    logic [7:0] pend;
    logic [7:0] en;
    logic       valid;
    logic [2:0] id;
    logic       busy;
    logic       none;
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;

  task automatic v(input logic [7:0] req, input logic we, input logic [7:0] wd,
                   input logic ack, input logic eoi, input logic [7:0] pend,
                   input logic [7:0] en, input logic valid, input logic [2:0] id,
                   input logic busy, input logic none);
    vec_t t;
    t.req = req; t.we = we; t.wd = wd; t.ack = ack; t.eoi = eoi;
    t.pend = pend; t.en = en; t.valid = valid; t.id = id; t.busy = busy; t.none = none;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input vec_t e);
    chk("pend_o",    step, bus.pend_o,          e.pend);
    chk("en_o",      step, bus.en_o,            e.en);
    chk("irq_valid", step, {7'd0, bus.irq_valid}, {7'd0, e.valid});
    chk("irq_id",    step, {5'd0, bus.irq_id},  {5'd0, e.id});
    chk("busy",      step, {7'd0, bus.busy},    {7'd0, e.busy});
    chk("none_pend", step, {7'd0, bus.none_pend}, {7'd0, e.none});
  endtask

  task automatic drive(input vec_t e);
    bus.req_i    = e.req;
    bus.en_we    = e.we;
    bus.en_wdata = e.wd;
    bus.irq_ack  = e.ack;
    bus.irq_eoi  = e.eoi;
  endtask

  initial begin
    vec_t z;
    //  req   we wd    ack eoi | pend  en    vld id busy none
    // single pulse, offer, ack, eoi
    v(8'h10, 0, 8'h00, 0, 0,   8'h10, 8'hFF, 0, 0, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h10, 8'hFF, 1, 4, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h00, 8'hFF, 0, 4, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h00, 8'hFF, 0, 4, 0, 1);
    // simultaneous rises 7 and 0
    v(8'h81, 0, 8'h00, 0, 0,   8'h81, 8'hFF, 0, 4, 0, 0);
    v(8'h81, 0, 8'h00, 0, 0,   8'h81, 8'hFF, 1, 7, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h01, 8'hFF, 0, 7, 1, 0);
    v(8'h00, 0, 8'h00, 0, 1,   8'h01, 8'hFF, 0, 7, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h01, 8'hFF, 1, 0, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h00, 8'hFF, 0, 0, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h00, 8'hFF, 0, 0, 0, 1);
    // no preemption of offer id 2 by line 6
    v(8'h04, 0, 8'h00, 0, 0,   8'h04, 8'hFF, 0, 0, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h04, 8'hFF, 1, 2, 0, 0);
    v(8'h40, 0, 8'h00, 0, 0,   8'h44, 8'hFF, 1, 2, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h44, 8'hFF, 1, 2, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h40, 8'hFF, 0, 2, 1, 0);
    v(8'h00, 0, 8'h00, 0, 1,   8'h40, 8'hFF, 0, 2, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h40, 8'hFF, 1, 6, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h00, 8'hFF, 0, 6, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h00, 8'hFF, 0, 6, 0, 1);
    // mask 0F: line 7 held back, line 1 served; ack in IDLE ignored
    v(8'h00, 1, 8'h0F, 0, 0,   8'h00, 8'h0F, 0, 6, 0, 1);
    v(8'h82, 0, 8'h00, 0, 0,   8'h82, 8'h0F, 0, 6, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h82, 8'h0F, 1, 1, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h80, 8'h0F, 0, 1, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h80, 8'h0F, 0, 1, 0, 1);
    v(8'h00, 0, 8'h00, 1, 0,   8'h80, 8'h0F, 0, 1, 0, 1);
    v(8'h00, 1, 8'hFF, 0, 0,   8'h80, 8'hFF, 0, 1, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h80, 8'hFF, 1, 7, 0, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h00, 8'hFF, 0, 7, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h00, 8'hFF, 0, 7, 0, 1);
    // re-rise in ack cycle; stray ack in SERVICE, stray eoi in OFFER, ack+eoi together
    v(8'h08, 0, 8'h00, 0, 0,   8'h08, 8'hFF, 0, 7, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h08, 8'hFF, 1, 3, 0, 0);
    v(8'h08, 0, 8'h00, 1, 0,   8'h08, 8'hFF, 0, 3, 1, 0);
    v(8'h00, 0, 8'h00, 1, 0,   8'h08, 8'hFF, 0, 3, 1, 0);
    v(8'h00, 0, 8'h00, 0, 1,   8'h08, 8'hFF, 0, 3, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h08, 8'hFF, 1, 3, 0, 0);
    v(8'h00, 0, 8'h00, 0, 1,   8'h08, 8'hFF, 1, 3, 0, 0);
    v(8'h00, 0, 8'h00, 1, 1,   8'h00, 8'hFF, 0, 3, 1, 1);
    v(8'h00, 0, 8'h00, 0, 0,   8'h00, 8'hFF, 0, 3, 1, 1);
    v(8'h00, 0, 8'h00, 0, 1,   8'h00, 8'hFF, 0, 3, 0, 1);
    // set up SERVICE with pend=24 and a narrowed mask, for the reset sequence
    v(8'h24, 1, 8'h3F, 0, 0,   8'h24, 8'h3F, 0, 3, 0, 0);
    v(8'h00, 0, 8'h00, 0, 0,   8'h24, 8'h3F, 1, 5, 0, 0);
    v(8'h20, 0, 8'h00, 1, 0,   8'h24, 8'h3F, 0, 5, 1, 0);

    rst = 1'b1;
    z.req = '0; z.we = 1'b0; z.wd = '0; z.ack = 1'b0; z.eoi = 1'b0;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    z.pend = 8'h00; z.en = 8'hFF; z.valid = 1'b0; z.id = 3'd0; z.busy = 1'b0; z.none = 1'b1;
    check_all(-1, z);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check_all(i, vq[i]);
    end

    // reset while in SERVICE: everything back to reset values in one edge
    z.req = 8'h24; z.we = 1'b0; z.wd = '0; z.ack = 1'b0; z.eoi = 1'b0;
    drive(z);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    z.pend = 8'h00; z.en = 8'hFF; z.valid = 1'b0; z.id = 3'd0; z.busy = 1'b0; z.none = 1'b1;
    check_all(100, z);
    // req_q was cleared by reset, so a held request is seen as a fresh rise
    @(posedge clk);
    #1;
    z.pend = 8'h24; z.none = 1'b0;
    check_all(101, z);
    @(posedge clk);
    #1;
    z.valid = 1'b1; z.id = 3'd5;
    check_all(102, z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
